scan_reg_bank: RTL and testbench

- Parametrised, clocked successor to the team's 8x4 select/num register file.
- Adds:
  - synchronous write port;
  - registered random-read port with write-first bypass;
  - per-entry valid bits;
  - synchronous bulk clear;
  - autonomous scan engine that streams every entry in address order, replacing the bench-driven num sweep.
- Sits between the input capture logic and the display/readout path.

---
 rtl/scan_reg_bank.sv | 160 ++++++++++++++++
 tb/tb_scan_reg_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_reg_bank.sv
// Parametrised register bank with a write port, a registered write-first read port, per-entry
// valid bits, synchronous bulk clear and an autonomous address-order scan engine.
// Optional: define SCAN_SKIP_EMPTY_EN to blank scan beats of never-written entries.
module scan_reg_bank #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    output logic              scan_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  wr_sel;

    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic              scan_busy_reg;
    logic [ADDR_W-1:0] scan_addr_reg;
    logic [DATA_W-1:0] scan_data_reg;
    logic              scan_valid_reg;
    logic              scan_done_reg;

    logic [DATA_W-1:0] beat_data;
    logic              beat_valid;

    // One-hot write decode; a clear cycle never writes.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && !clr && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            valid_reg <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i]   <= wr_data;
                    valid_reg[i] <= 1'b1;
                end
            end
        end
    end

    // Random read returns the value being written this edge when addresses collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else if (clr) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_reg  <= wr_data;
            rd_valid_reg <= 1'b1;
        end else begin
            rd_data_reg  <= mem_reg[rd_addr];
            rd_valid_reg <= valid_reg[rd_addr];
        end
    end

    // Scan beats sample the array before this edge's write lands (read-before-write).
`ifdef SCAN_SKIP_EMPTY_EN
    assign beat_valid = valid_reg[ptr_reg];
    assign beat_data  = valid_reg[ptr_reg] ? mem_reg[ptr_reg] : '0;
`else
    assign beat_valid = 1'b1;
    assign beat_data  = mem_reg[ptr_reg];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            scan_busy_reg  <= 1'b0;
            scan_addr_reg  <= '0;
            scan_data_reg  <= '0;
            scan_valid_reg <= 1'b0;
            scan_done_reg  <= 1'b0;
        end else if (clr) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            scan_busy_reg  <= 1'b0;
            scan_valid_reg <= 1'b0;
            scan_done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    scan_done_reg <= 1'b0;
                    if (scan_start) begin
                        state_reg     <= ST_RUN;
                        ptr_reg       <= '0;
                        scan_busy_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    scan_addr_reg  <= ptr_reg;
                    scan_data_reg  <= beat_data;
                    scan_valid_reg <= beat_valid;
                    scan_done_reg  <= 1'b0;
                    ptr_reg        <= ptr_reg + ADDR_W'(1);
                    if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    scan_valid_reg <= 1'b0;
                    scan_busy_reg  <= 1'b0;
                    scan_done_reg  <= 1'b1;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    scan_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data    = rd_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign scan_busy  = scan_busy_reg;
    assign scan_addr  = scan_addr_reg;
    assign scan_data  = scan_data_reg;
    assign scan_valid = scan_valid_reg;
    assign scan_done  = scan_done_reg;

endmodule

// File: tb/tb_scan_reg_bank.sv
// Self-checking bench for scan_reg_bank: directed scenarios plus random traffic, checked
// against a cycle-count model of the bank, read port and scan stream.
module tb_scan_reg_bank;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              clr = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              scan_start = 1'b0;
    logic              scan_busy;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_data;
    logic              scan_valid;
    logic              scan_done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int mem_m [DEPTH];
    bit val_m [DEPTH];
    int e_rd, e_sa, e_sd;
    bit e_rv, e_sv, e_busy, e_done;
    bit sc_active;
    int sc_j;   // edges elapsed since the accepted start

    scan_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_addr(scan_addr),
        .scan_data(scan_data), .scan_valid(scan_valid), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":rd_data"},    32'(rd_data),    32'(e_rd));
        chk({ctx, ":rd_valid"},   32'(rd_valid),   32'(e_rv));
        chk({ctx, ":scan_busy"},  32'(scan_busy),  32'(e_busy));
        chk({ctx, ":scan_valid"}, 32'(scan_valid), 32'(e_sv));
        chk({ctx, ":scan_done"},  32'(scan_done),  32'(e_done));
        chk({ctx, ":scan_addr"},  32'(scan_addr),  32'(e_sa));
        chk({ctx, ":scan_data"},  32'(scan_data),  32'(e_sd));
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = 0;
            val_m[i] = 0;
        end
        e_rd = 0; e_rv = 0; e_sa = 0; e_sd = 0; e_sv = 0; e_busy = 0; e_done = 0;
        sc_active = 0; sc_j = 0;
    endtask

    // Asynchronous reset: asserted off-edge, outputs must drop before the next clock.
    task automatic async_reset(input string ctx);
        #2 rst_n = 1'b0;
        wr_en = 1'b0; clr = 1'b0; scan_start = 1'b0;
        #1;
        model_reset();
        check_all(ctx);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset %s", ctx);
    endtask

    task automatic step(input bit we, input int wa, input int wd, input bit c,
                        input int ra, input bit st, input string ctx);
        int p;
        @(negedge clk);
        wr_en = we; wr_addr = ADDR_W'(wa); wr_data = DATA_W'(wd);
        clr = c; rd_addr = ADDR_W'(ra); scan_start = st;
        @(posedge clk);
        // read port
        if (c) begin
            e_rd = 0; e_rv = 0;
        end else if (we && wa == ra) begin
            e_rd = wd; e_rv = 1;
        end else begin
            e_rd = mem_m[ra]; e_rv = val_m[ra];
        end
        // scan stream, described by edge count since the start
        if (c) begin
            sc_active = 0; e_busy = 0; e_sv = 0; e_done = 0;
        end else if (!sc_active) begin
            e_done = 0;
            if (st) begin
                sc_active = 1; sc_j = 0; e_busy = 1;
            end
        end else begin
            sc_j++;
            if (sc_j <= DEPTH) begin
                p = sc_j - 1;
                e_sa = p;
`ifdef SCAN_SKIP_EMPTY_EN
                e_sv = val_m[p];
                e_sd = val_m[p] ? mem_m[p] : 0;
`else
                e_sv = 1;
                e_sd = mem_m[p];
`endif
            end else begin
                e_sv = 0; e_busy = 0; e_done = 1; sc_active = 0;
            end
        end
        // array update after the scan/read saw the old contents
        if (c) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_m[i] = 0;
                val_m[i] = 0;
            end
        end else if (we) begin
            mem_m[wa] = wd;
            val_m[wa] = 1;
        end
        #1;
        $display("%s we=%0b wa=%0d wd=%0h clr=%0b ra=%0d st=%0b | rd=%0h/%0b scan a=%0d d=%0h v=%0b busy=%0b done=%0b",
                 ctx, we, wa, wd, c, ra, st, rd_data, rd_valid, scan_addr, scan_data,
                 scan_valid, scan_busy, scan_done);
        check_all(ctx);
    endtask

    task automatic idle(input int n, input int ra, input string ctx);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, ra, 0, ctx);
    endtask

    task automatic fill(input string ctx);
        for (int i = 0; i < DEPTH; i++) step(1, i, i + 1, 0, 0, 0, ctx);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("por");
        async_reset("init");

        // Fill and random-read
        fill("fill");
        step(0, 0, 0, 0, 3, 0, "rd3");
        step(0, 0, 0, 0, 0, 0, "rd0");

        // Unwritten read, then write-first bypass
        async_reset("rst2");
        step(0, 0, 0, 0, 5, 0, "rd5_empty");
        step(1, 5, 4'hA, 0, 5, 0, "bypass5");
        step(0, 0, 0, 0, 5, 0, "rd5_after");

        // Full scan, restart request mid-run ignored, restart right after done accepted
        async_reset("rst3");
        fill("fill3");
        step(0, 0, 0, 0, 0, 1, "scan_start");
        idle(3, 1, "scan_run");
        step(0, 0, 0, 0, 2, 1, "scan_restart_ignored");
        idle(5, 2, "scan_run");
        step(0, 0, 0, 0, 2, 1, "scan_start_in_done");
        step(0, 0, 0, 0, 2, 1, "scan_start_after_done");
        idle(10, 4, "scan2_run");

        // Writes during a scan: later address is streamed new, passed address is not
        step(0, 0, 0, 0, 0, 1, "scan3_start");
        step(0, 0, 0, 0, 0, 0, "scan3_b0");
        step(0, 0, 0, 0, 0, 0, "scan3_b1");
        step(1, 6, 4'hF, 0, 6, 0, "scan3_b2_wr6");
        step(1, 1, 4'hE, 0, 1, 0, "scan3_b3_wr1");
        idle(6, 1, "scan3_run");

        // Clear aborts the scan, drops the same-cycle write and invalidates everything
        step(0, 0, 0, 0, 0, 1, "scan4_start");
        idle(4, 0, "scan4_run");
        step(1, 3, 4'h9, 1, 3, 1, "scan4_clr");
        idle(3, 0, "after_clr");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, i, 0, "clr_rd");

        // Sparse contents scanned
        async_reset("rst5");
        step(1, 2, 4'h7, 0, 0, 0, "sparse_wr2");
        step(1, 5, 4'hC, 0, 0, 0, "sparse_wr5");
        step(0, 0, 0, 0, 0, 1, "sparse_start");
        idle(10, 2, "sparse_run");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(1, 0) == 1), $urandom_range(DEPTH - 1, 0),
                 $urandom_range(15, 0), ($urandom_range(40, 0) == 0),
                 $urandom_range(DEPTH - 1, 0), ($urandom_range(6, 0) == 0), "rand");
        end

        // Reset in the middle of a scan
        fill("fill6");
        step(0, 0, 0, 0, 0, 1, "scan6_start");
        idle(3, 0, "scan6_run");
        async_reset("midscan");
        idle(12, 0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
